mem_arbiter: RTL and testbench

Two-requester memory arbiter between the tightly coupled memories and the single external memory port. Port 0 carries the instruction-side miss/pass-through stream and port 1 the data-side stream, which includes the dtim miss, ldst and fence write-back traffic. Each port presents single-cycle request pulses and then waits for `mem_ready`. The block captures each pulse, grants one request at a time with round-robin priority, forwards it downstream, and routes the response back to its owner.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter funnelling instruction and data requests onto one
// external memory port, with one-entry capture buffers and combinational response routing.
package mem_arbiter_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_spec;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  memory_in,
    input  mem_out_type memory_out
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t     state;
    logic       prio;
    logic       owner;
    logic [1:0] pend;
    mem_in_type req_buf [2];

    mem_in_type port_req [2];
    logic       grant;
    logic       issue;
    logic [1:0] ready;

    assign port_req[0] = imem_in;
    assign port_req[1] = dmem_in;

    always_comb begin
        grant    = (pend == 2'b11) ? prio : pend[1];
        issue    = (state == IDLE) && (pend != 2'b00);
        ready[0] = (state == WAIT) && memory_out.mem_ready && !owner;
        ready[1] = (state == WAIT) && memory_out.mem_ready && owner;
    end

    always_comb begin
        memory_in = '0;
        if (issue) begin
            memory_in           = req_buf[grant];
            memory_in.mem_valid = 1'b1;
        end
    end

    always_comb begin
        imem_out           = '0;
        dmem_out           = '0;
        imem_out.mem_ready = ready[0];
        dmem_out.mem_ready = ready[1];
        if (ready[0]) imem_out.mem_rdata = memory_out.mem_rdata;
        if (ready[1]) dmem_out.mem_rdata = memory_out.mem_rdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            prio    <= 1'b1;
            owner   <= 1'b0;
            pend    <= '0;
            req_buf <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (pend != 2'b00) begin
                        owner <= grant;
                        prio  <= ~grant;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (memory_out.mem_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // The later reload wins over the release, so a pulse in the response cycle is kept.
            for (int unsigned i = 0; i < 2; i++) begin
                if (ready[i[0]]) pend[i[0]] <= 1'b0;
                if (port_req[i[0]].mem_valid && (!pend[i[0]] || ready[i[0]])) begin
                    pend[i[0]]    <= 1'b1;
                    req_buf[i[0]] <= port_req[i[0]];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter, checked cycle by cycle against a
// transaction-level model of the two request slots and the single outstanding access.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    mem_in_type  imem_in = '0;
    mem_out_type imem_out;
    mem_in_type  dmem_in = '0;
    mem_out_type dmem_out;
    mem_in_type  memory_in;
    mem_out_type memory_out = '0;

    mem_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .imem_in    (imem_in),
        .imem_out   (imem_out),
        .dmem_in    (dmem_in),
        .dmem_out   (dmem_out),
        .memory_in  (memory_in),
        .memory_out (memory_out)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model: what each port is waiting on, who holds the memory, who is favoured.
    bit         m_pend [2];
    mem_in_type m_req  [2];
    int         m_busy;
    int         m_favour;
    int         m_wait;
    int         m_delay;
    int         m_accepted [2];

    int          fixed_delay = 1;
    bit          use_fixed_rdata = 1'b0;
    logic [31:0] fixed_rdata = '0;

    int          rdy_cnt [2];
    logic [31:0] last_rdata [2];
    int          valid_cnt = 0;
    logic [31:0] issued_addr [$];
    int          issue_cyc [$];
    mem_in_type  last_issued;

    function automatic mem_in_type mk(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, input logic f,
                                      input logic sp, input logic in);
        mk           = '0;
        mk.mem_addr  = a;
        mk.mem_wdata = d;
        mk.mem_wstrb = s;
        mk.mem_fence = f;
        mk.mem_spec  = sp;
        mk.mem_instr = in;
    endfunction

    task automatic model_reset();
        m_pend   = '{0, 0};
        m_req    = '{default: '0};
        m_busy   = -1;
        m_favour = 1;
        m_wait   = 0;
        m_delay  = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        assert (memory_in === '0) else begin
            miscompares++;
            $error("FAIL %s memory_in got=%h exp=0", tag, memory_in);
        end
        vectors++;
        assert (imem_out === '0) else begin
            miscompares++;
            $error("FAIL %s imem_out got=%h exp=0", tag, imem_out);
        end
        vectors++;
        assert (dmem_out === '0) else begin
            miscompares++;
            $error("FAIL %s dmem_out got=%h exp=0", tag, dmem_out);
        end
    endtask

    task automatic do_reset();
        #2;
        reset                 = 1'b1;
        imem_in               = '0;
        dmem_in               = '0;
        memory_out.mem_ready  = 1'b1;
        memory_out.mem_rdata  = $urandom;
        #1;
        check_all_zero("in_reset");
        @(posedge clock);
        #2;
        memory_out = '0;
        reset      = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit iv, input mem_in_type ir, input bit dv,
                        input mem_in_type dr, input bit late_rdy);
        mem_in_type  exp_mi;
        mem_out_type exp_o [2];
        int          win;
        bit          rdy;
        logic [31:0] rd;

        @(negedge clock);
        imem_in           = ir;
        imem_in.mem_valid = iv;
        dmem_in           = dr;
        dmem_in.mem_valid = dv;
        rdy = late_rdy || (m_busy >= 0 && m_wait == m_delay);
        rd  = use_fixed_rdata ? fixed_rdata : $urandom;
        memory_out.mem_rdata = rd;
        memory_out.mem_ready = rdy;

        win = -1;
        if (m_busy < 0) begin
            if (m_pend[0] && m_pend[1]) win = m_favour;
            else if (m_pend[1])         win = 1;
            else if (m_pend[0])         win = 0;
        end
        exp_mi = '0;
        if (win >= 0) begin
            exp_mi           = m_req[win];
            exp_mi.mem_valid = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            exp_o[p] = '0;
            if (m_busy == p && rdy) begin
                exp_o[p].mem_ready = 1'b1;
                exp_o[p].mem_rdata = rd;
            end
        end

        #1;
        vectors++;
        assert (memory_in === exp_mi) else begin
            miscompares++;
            $error("FAIL memory_in cyc=%0d got=%h exp=%h", cyc, memory_in, exp_mi);
        end
        vectors++;
        assert (imem_out === exp_o[0]) else begin
            miscompares++;
            $error("FAIL imem_out cyc=%0d got=%h exp=%h", cyc, imem_out, exp_o[0]);
        end
        vectors++;
        assert (dmem_out === exp_o[1]) else begin
            miscompares++;
            $error("FAIL dmem_out cyc=%0d got=%h exp=%h", cyc, dmem_out, exp_o[1]);
        end

        if (memory_in.mem_valid) begin
            valid_cnt++;
            issued_addr.push_back(memory_in.mem_addr);
            issue_cyc.push_back(cyc);
            last_issued = memory_in;
        end
        if (imem_out.mem_ready) begin rdy_cnt[0]++; last_rdata[0] = imem_out.mem_rdata; end
        if (dmem_out.mem_ready) begin rdy_cnt[1]++; last_rdata[1] = dmem_out.mem_rdata; end

        if (win >= 0) begin
            m_busy   = win;
            m_favour = 1 - win;
            m_wait   = 1;
            m_delay  = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4);
        end else if (m_busy >= 0) begin
            if (rdy) begin
                m_pend[m_busy] = 1'b0;
                m_busy         = -1;
            end else begin
                m_wait++;
            end
        end
        if (iv && !m_pend[0]) begin m_pend[0] = 1'b1; m_req[0] = imem_in; m_accepted[0]++; end
        if (dv && !m_pend[1]) begin m_pend[1] = 1'b1; m_req[1] = dmem_in; m_accepted[1]++; end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int c0;
        int base0;
        int base1;
        int vbase;
        mem_in_type st;

        rdy_cnt     = '{0, 0};
        m_accepted  = '{0, 0};
        last_rdata  = '{default: '0};
        last_issued = '0;
        model_reset();
        do_reset();

        // Single data read, memory answers three cycles after valid
        fixed_delay     = 3;
        use_fixed_rdata = 1'b1;
        fixed_rdata     = 32'hDEAD_BEEF;
        issue_cyc.delete();
        c0 = cyc;
        step(1'b0, '0, 1'b1, mk(32'h0000_1004, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0), 1'b0);
        idle(6);
        use_fixed_rdata = 1'b0;
        chk("t1_valid_count", 32'(valid_cnt), 32'd1);
        chk("t1_valid_cycle", 32'(issue_cyc[0]), 32'(c0 + 1));
        chk("t1_dready_count", 32'(rdy_cnt[1]), 32'd1);
        chk("t1_irdy_count", 32'(rdy_cnt[0]), 32'd0);
        chk("t1_rdata", last_rdata[1], 32'hDEAD_BEEF);

        // Simultaneous first requests after reset: data side first
        do_reset();
        fixed_delay = 1;
        issued_addr.delete();
        issue_cyc.delete();
        base0 = rdy_cnt[0];
        base1 = rdy_cnt[1];
        c0 = cyc;
        step(1'b1, mk(32'h0000_0100, '0, 4'h0, 1'b0, 1'b0, 1'b1), 1'b1,
             mk(32'h0000_2200, '0, 4'h0, 1'b0, 1'b0, 1'b0), 1'b0);
        idle(6);
        chk("t2_first_addr", issued_addr[0], 32'h0000_2200);
        chk("t2_second_addr", issued_addr[1], 32'h0000_0100);
        chk("t2_first_cycle", 32'(issue_cyc[0]), 32'(c0 + 1));
        chk("t2_second_cycle", 32'(issue_cyc[1]), 32'(c0 + 3));
        chk("t2_irdy", 32'(rdy_cnt[0] - base0), 32'd1);
        chk("t2_drdy", 32'(rdy_cnt[1] - base1), 32'd1);

        // Store pass-through on the instruction port
        fixed_delay = 2;
        base0 = rdy_cnt[0];
        st = mk(32'h0000_3008, 32'h1234_5678, 4'b0011, 1'b1, 1'b0, 1'b0);
        step(1'b1, st, 1'b0, '0, 1'b0);
        idle(5);
        st.mem_valid = 1'b1;
        chk("t3_fields_lo", last_issued[31:0], st[31:0]);
        chk("t3_fields_mid", last_issued[63:32], st[63:32]);
        chk("t3_fields_hi", 32'(last_issued[71:64]), 32'(st[71:64]));
        chk("t3_irdy", 32'(rdy_cnt[0] - base0), 32'd1);

        // Back-to-back on port 1 while port 0 waits: grants go 1,0,1
        fixed_delay = 2;
        issued_addr.delete();
        base0 = rdy_cnt[0];
        base1 = rdy_cnt[1];
        step(1'b0, '0, 1'b1, mk(32'h0000_4000, '0, 4'h0, 1'b0, 1'b0, 1'b0), 1'b0);
        step(1'b1, mk(32'h0000_4100, '0, 4'h0, 1'b0, 1'b0, 1'b1), 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, mk(32'h0000_4200, '0, 4'hF, 1'b0, 1'b1, 1'b0), 1'b0);
        idle(10);
        chk("t4_grant0", issued_addr[0], 32'h0000_4000);
        chk("t4_grant1", issued_addr[1], 32'h0000_4100);
        chk("t4_grant2", issued_addr[2], 32'h0000_4200);
        chk("t4_irdy", 32'(rdy_cnt[0] - base0), 32'd1);
        chk("t4_drdy", 32'(rdy_cnt[1] - base1), 32'd2);

        // Reset while waiting, then a stray ready from downstream
        fixed_delay = 4;
        step(1'b0, '0, 1'b1, mk(32'h0000_5000, '0, 4'h0, 1'b0, 1'b0, 1'b0), 1'b0);
        idle(2);
        base0 = rdy_cnt[0];
        base1 = rdy_cnt[1];
        vbase = valid_cnt;
        do_reset();
        step(1'b0, '0, 1'b0, '0, 1'b1);
        idle(3);
        chk("t5_irdy", 32'(rdy_cnt[0] - base0), 32'd0);
        chk("t5_drdy", 32'(rdy_cnt[1] - base1), 32'd0);
        chk("t5_no_valid", 32'(valid_cnt - vbase), 32'd0);
        #1;
        check_all_zero("t5_idle");

        // Duplicate pulse while pending is dropped
        fixed_delay = 3;
        issued_addr.delete();
        base1 = rdy_cnt[1];
        step(1'b0, '0, 1'b1, mk(32'h0000_6000, '0, 4'h0, 1'b0, 1'b0, 1'b0), 1'b0);
        step(1'b0, '0, 1'b1, mk(32'h0000_6666, '0, 4'h0, 1'b0, 1'b0, 1'b0), 1'b0);
        idle(6);
        chk("t6_issue_count", 32'(issued_addr.size()), 32'd1);
        chk("t6_addr", issued_addr[0], 32'h0000_6000);
        chk("t6_drdy", 32'(rdy_cnt[1] - base1), 32'd1);

        // Random traffic with random memory latency
        do_reset();
        fixed_delay = 0;
        m_accepted  = '{0, 0};
        base0 = rdy_cnt[0];
        base1 = rdy_cnt[1];
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) == 0,
                 mk($urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)),
                 $urandom_range(0, 3) == 0,
                 mk($urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)),
                 1'b0);
        end
        idle(12);
        chk("rand_irdy_total", 32'(rdy_cnt[0] - base0), 32'(m_accepted[0]));
        chk("rand_drdy_total", 32'(rdy_cnt[1] - base1), 32'(m_accepted[1]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
